// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I control unit: a six-state FSM (IF, ID, EX, MEM, WB, HALT)
// that drives the datapath control strobes. It also keeps a retired-instruction counter.
// The control outputs are combinational from the current state and the live
// inputs, so the datapath sees them within the same cycle.
module multi_cycle_control_unit #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [6:0]             opcode,
    input  logic                   alu_bcond,
    input  logic                   mem_ready,
    input  logic                   ecall_halt,
    output logic                   pc_write,
    output logic [1:0]             pc_source,
    output logic                   i_or_d,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             alu_op,
    output logic                   reg_write,
    output logic [1:0]             wb_sel,
    output logic                   is_ecall,
    output logic                   halted,
    output logic [2:0]             state,
    output logic [COUNT_WIDTH-1:0] instret
);

    // RV32I major opcodes (inst[6:0])
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    // pc_source encodings
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_PC4    = 2'b10;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic                   retire_s;
    logic [COUNT_WIDTH-1:0] instret_r;

    // Opcodes that the decoder recognises; anything else retires as a NOP
    function automatic logic known_opcode(input logic [6:0] op);
        logic known;
        case (op)
            OP_RTYPE, OP_IARITH, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL: known = 1'b1;
            default:                              known = 1'b0;
        endcase
        return known;
    endfunction

    assign state   = state_r;
    assign instret = instret_r;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IF;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Retired-instruction counter: one count per PC update or entry into HALT
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            instret_r <= '0;
        end else if (retire_s) begin
            instret_r <= instret_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            instret_r <= instret_r;
        end
    end

    // Next-state and control-strobe decode
    always_comb begin
        next_state_s = ST_IF;
        pc_write     = 1'b0;
        pc_source    = 2'b00;
        i_or_d       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        reg_write    = 1'b0;
        wb_sel       = 2'b00;
        is_ecall     = 1'b0;
        halted       = 1'b0;
        retire_s     = 1'b0;

        case (state_r)
            ST_IF: begin
                mem_read = 1'b1;
                i_or_d   = 1'b0;
                ir_write = mem_ready;
                if (mem_ready) begin
                    next_state_s = ST_ID;
                end else begin
                    next_state_s = ST_IF;
                end
            end

            ST_ID: begin
                // ALUOut <= PC + imm, used later as the JAL / taken-branch target
                alu_src_a = 1'b0;
                alu_src_b = 2'b10;
                alu_op    = 2'b00;
                is_ecall  = (opcode == OP_ECALL);
                if (opcode == OP_ECALL) begin
                    if (ecall_halt) begin
                        next_state_s = ST_HALT;
                    end else begin
                        pc_write     = 1'b1;
                        pc_source    = PCS_PC4;
                        next_state_s = ST_IF;
                    end
                end else if (!known_opcode(opcode)) begin
                    pc_write     = 1'b1;
                    pc_source    = PCS_PC4;
                    next_state_s = ST_IF;
                end else begin
                    next_state_s = ST_EX;
                end
            end

            ST_EX: begin
                case (opcode)
                    OP_RTYPE: begin
                        alu_src_a    = 1'b1;
                        alu_src_b    = 2'b00;
                        alu_op       = 2'b10;
                        next_state_s = ST_WB;
                    end
                    OP_IARITH: begin
                        alu_src_a    = 1'b1;
                        alu_src_b    = 2'b10;
                        alu_op       = 2'b11;
                        next_state_s = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a    = 1'b1;
                        alu_src_b    = 2'b10;
                        alu_op       = 2'b00;
                        next_state_s = ST_MEM;
                    end
                    OP_BRANCH: begin
                        alu_src_a    = 1'b1;
                        alu_src_b    = 2'b00;
                        alu_op       = 2'b01;
                        pc_write     = 1'b1;
                        pc_source    = alu_bcond ? PCS_ALUOUT : PCS_PC4;
                        next_state_s = ST_IF;
                    end
                    OP_JAL: begin
                        reg_write    = 1'b1;
                        wb_sel       = 2'b10;
                        pc_write     = 1'b1;
                        pc_source    = PCS_ALUOUT;
                        next_state_s = ST_IF;
                    end
                    OP_JALR: begin
                        alu_src_a    = 1'b1;
                        alu_src_b    = 2'b10;
                        alu_op       = 2'b00;
                        reg_write    = 1'b1;
                        wb_sel       = 2'b10;
                        pc_write     = 1'b1;
                        pc_source    = PCS_ALU;
                        next_state_s = ST_IF;
                    end
                    default: begin
                        next_state_s = ST_IF;
                    end
                endcase
            end

            ST_MEM: begin
                // Strobes are held constant for the whole stall
                i_or_d = 1'b1;
                if (opcode == OP_LOAD) begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        next_state_s = ST_WB;
                    end else begin
                        next_state_s = ST_MEM;
                    end
                end else if (opcode == OP_STORE) begin
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        pc_write     = 1'b1;
                        pc_source    = PCS_PC4;
                        next_state_s = ST_IF;
                    end else begin
                        next_state_s = ST_MEM;
                    end
                end else begin
                    next_state_s = ST_IF;
                end
            end

            ST_WB: begin
                reg_write    = 1'b1;
                wb_sel       = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
                pc_write     = 1'b1;
                pc_source    = PCS_PC4;
                next_state_s = ST_IF;
            end

            ST_HALT: begin
                halted       = 1'b1;
                next_state_s = ST_HALT;
            end

            default: begin
                next_state_s = ST_IF;
            end
        endcase

        retire_s = pc_write || ((state_r == ST_ID) && (next_state_s == ST_HALT));
    end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed-vector bench for multi_cycle_control_unit: walks each instruction
// class through the FSM and compares state, control strobes and instret
// against hand-computed values.
module tb_multi_cycle_control_unit;

    logic        clk;
    logic        reset_n;
    logic [6:0]  opcode;
    logic        alu_bcond;
    logic        mem_ready;
    logic        ecall_halt;
    logic        pc_write;
    logic [1:0]  pc_source;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        is_ecall;
    logic        halted;
    logic [2:0]  state;
    logic [31:0] instret;
    logic [16:0] ctrl_obs;

    int vectors;
    int miscompares;

    multi_cycle_control_unit #(.COUNT_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .alu_bcond(alu_bcond),
        .mem_ready(mem_ready), .ecall_halt(ecall_halt), .pc_write(pc_write),
        .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .wb_sel(wb_sel), .is_ecall(is_ecall), .halted(halted),
        .state(state), .instret(instret)
    );

    assign ctrl_obs = {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
                       alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, is_ecall, halted};

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pack an expected control vector in the same order as ctrl_obs
    function automatic logic [16:0] ctl(
        input logic pw, input logic [1:0] ps, input logic iod, input logic mr,
        input logic mw, input logic irw, input logic asa, input logic [1:0] asb,
        input logic [1:0] aop, input logic rw, input logic [1:0] wbs,
        input logic ie, input logic h);
        return {pw, ps, iod, mr, mw, irw, asa, asb, aop, rw, wbs, ie, h};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check state and strobes for the current cycle, then advance one clock
    task automatic step(input string tag, input logic [2:0] st, input logic [16:0] c);
        #1;
        check_val({tag, " state"}, {61'd0, state}, {61'd0, st});
        check_val({tag, " ctrl"}, {47'd0, ctrl_obs}, {47'd0, c});
        @(posedge clk);
        #2;
    endtask

    task automatic check_instret(input string tag, input logic [31:0] exp);
        #1;
        check_val({tag, " instret"}, {32'd0, instret}, {32'd0, exp});
    endtask

    logic [16:0] c_if, c_if_stall, c_id, c_wb_alu;

    initial begin
        vectors     = 0;
        miscompares = 0;
        c_if       = ctl(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
        c_if_stall = ctl(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
        c_id       = ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
        c_wb_alu   = ctl(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);

        reset_n    = 1'b0;
        opcode     = 7'b0110011;
        alu_bcond  = 1'b0;
        mem_ready  = 1'b0;
        ecall_halt = 1'b0;
        #2;
        @(posedge clk); #2;
        @(posedge clk); #2;

        // Reset state
        check_instret("reset", 32'd0);
        step("reset", 3'd0, c_if_stall);
        reset_n = 1'b1;

        // IF stall holds without ir_write
        step("if_stall", 3'd0, c_if_stall);
        check_instret("if_stall", 32'd0);

        // R-type
        mem_ready = 1'b1;
        opcode    = 7'b0110011;
        step("r_if", 3'd0, c_if);
        step("r_id", 3'd1, c_id);
        step("r_ex", 3'd2, ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0));
        check_instret("r_ex", 32'd0);
        step("r_wb", 3'd4, c_wb_alu);
        check_instret("r_done", 32'd1);

        // LOAD with 3 stall cycles in MEM; mem_ready low in ID/EX is ignored
        opcode = 7'b0000011;
        step("ld_if", 3'd0, c_if);
        mem_ready = 1'b0;
        step("ld_id", 3'd1, c_id);
        step("ld_ex", 3'd2, ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            step("ld_mem_stall", 3'd3, ctl(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
        end
        mem_ready = 1'b1;
        step("ld_mem", 3'd3, ctl(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
        step("ld_wb", 3'd4, ctl(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0));
        check_instret("ld_done", 32'd2);

        // Taken branch
        opcode    = 7'b1100011;
        alu_bcond = 1'b1;
        step("bt_if", 3'd0, c_if);
        step("bt_id", 3'd1, c_id);
        step("bt_ex", 3'd2, ctl(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0));
        check_instret("bt_done", 32'd3);

        // Not-taken branch
        alu_bcond = 1'b0;
        step("bn_if", 3'd0, c_if);
        step("bn_id", 3'd1, c_id);
        step("bn_ex", 3'd2, ctl(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0));
        check_instret("bn_done", 32'd4);

        // JAL
        opcode = 7'b1101111;
        step("jal_if", 3'd0, c_if);
        step("jal_id", 3'd1, c_id);
        step("jal_ex", 3'd2, ctl(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0));
        check_instret("jal_done", 32'd5);

        // JALR
        opcode = 7'b1100111;
        step("jalr_if", 3'd0, c_if);
        step("jalr_id", 3'd1, c_id);
        step("jalr_ex", 3'd2, ctl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0));
        check_instret("jalr_done", 32'd6);

        // I-type arithmetic
        opcode = 7'b0010011;
        step("ia_if", 3'd0, c_if);
        step("ia_id", 3'd1, c_id);
        step("ia_ex", 3'd2, ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0));
        step("ia_wb", 3'd4, c_wb_alu);
        check_instret("ia_done", 32'd7);

        // Unknown opcode retires as a NOP from ID
        opcode = 7'b1111111;
        step("unk_if", 3'd0, c_if);
        step("unk_id", 3'd1, ctl(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
        check_instret("unk_done", 32'd8);

        // ECALL without halt condition
        opcode     = 7'b1110011;
        ecall_halt = 1'b0;
        step("ec0_if", 3'd0, c_if);
        step("ec0_id", 3'd1, ctl(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0));
        check_instret("ec0_done", 32'd9);

        // STORE completing after one stall
        opcode = 7'b0100011;
        step("st_if", 3'd0, c_if);
        step("st_id", 3'd1, c_id);
        step("st_ex", 3'd2, ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
        mem_ready = 1'b0;
        step("st_mem_stall", 3'd3, ctl(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
        mem_ready = 1'b1;
        step("st_mem", 3'd3, ctl(1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
        check_instret("st_done", 32'd10);

        // STORE abandoned by reset during a MEM stall
        step("sta_if", 3'd0, c_if);
        step("sta_id", 3'd1, c_id);
        step("sta_ex", 3'd2, ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
        mem_ready = 1'b0;
        step("sta_mem", 3'd3, ctl(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
        reset_n = 1'b0;
        step("sta_mem_rst", 3'd3, ctl(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
        check_instret("sta_rst", 32'd0);
        reset_n = 1'b1;
        step("sta_after", 3'd0, c_if_stall);

        // ECALL with halt condition: HALT held for 10 cycles
        opcode     = 7'b1110011;
        ecall_halt = 1'b1;
        mem_ready  = 1'b1;
        step("ech_if", 3'd0, c_if);
        step("ech_id", 3'd1, ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0));
        check_instret("ech_halt", 32'd1);
        for (int i = 0; i < 10; i++) begin
            mem_ready = i[0];
            step("halt", 3'd5, ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1));
        end
        check_instret("halt_hold", 32'd1);

        // Reset leaves HALT
        reset_n = 1'b0;
        @(posedge clk); #2;
        reset_n   = 1'b1;
        mem_ready = 1'b0;
        check_instret("halt_rst", 32'd0);
        step("halt_rst", 3'd0, c_if_stall);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control_unit.md
MULTI_CYCLE_CONTROL_UNIT -- requirements
Module: multi_cycle_control_unit

Interface
REQ-001 SHALL have parameter: COUNT_WIDTH, 32, width of the retired-instruction counter.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  single clock; all state changes on rising edge
- reset_n  in  1  synchronous, active-low reset
- opcode  in  7  inst[6:0] from instruction register; opcode macros from opcodes.v
- alu_bcond  in  1  branch condition from ALU, valid in EX
- mem_ready  in  1  memory handshake; access completes on a cycle with mem_ready=1
- ecall_halt  in  1  high when the ECALL halt condition holds (x17==10)
- pc_write  out  1  PC load enable
- pc_source  out  2  00 ALU result & ~1, 01 ALUOut reg, 10 PC+4
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read, mem_write  out  1 each  memory strobes
- ir_write  out  1  instruction register load
- alu_src_a  out  1  0 PC, 1 rs1
- alu_src_b  out  2  00 rs2, 01 constant 4, 10 immediate
- alu_op  out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
- reg_write  out  1  register-file write enable
- wb_sel  out  2  00 ALUOut, 01 MDR, 10 PC+4
- is_ecall, halted  out  1 each  ECALL decode; halt status
- state  out  3  current state (debug)
- instret  out  COUNT_WIDTH  retired-instruction count

Function
REQ-003 SHALL be an FSM with states IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to IF.
REQ-004 SHALL drive every output not listed for a state to 0; outputs SHALL be combinational from state, opcode, alu_bcond, mem_ready, ecall_halt.
REQ-005 IF: mem_read=1, i_or_d=0, ir_write=mem_ready; stay while mem_ready=0; ->ID when mem_ready=1.
REQ-006 ID: alu_src_a=0, alu_src_b=10, alu_op=00 (ALUOut<=PC+imm); is_ecall=1 when opcode==ECALL.
REQ-007 ID next state: ECALL with ecall_halt=1 ->HALT; ECALL with ecall_halt=0 -> pc_write=1, pc_source=10, ->IF; unknown opcode -> pc_write=1, pc_source=10, ->IF (NOP); else ->EX.
REQ-008 EX R-type: alu_src_a=1, alu_src_b=00, alu_op=10 ->WB; I-arith: alu_src_a=1, alu_src_b=10, alu_op=11 ->WB.
REQ-009 EX LOAD/STORE: alu_src_a=1, alu_src_b=10, alu_op=00 ->MEM.
REQ-010 EX BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write=1, pc_source=alu_bcond?01:10 ->IF.
REQ-011 EX JAL: reg_write=1, wb_sel=10, pc_write=1, pc_source=01 ->IF; JALR: alu_src_a=1, alu_src_b=10, alu_op=00, reg_write=1, wb_sel=10, pc_write=1, pc_source=00 ->IF.
REQ-012 MEM: i_or_d=1; LOAD mem_read=1, STORE mem_write=1; stay while mem_ready=0; LOAD ->WB on mem_ready; STORE on mem_ready: pc_write=1, pc_source=10 ->IF.
REQ-013 WB: reg_write=1, wb_sel=(LOAD?01:00), pc_write=1, pc_source=10 ->IF.
REQ-014 HALT: halted=1, all strobes 0; remains until reset_n=0.
REQ-015 instret SHALL increment by 1 on every edge where pc_write=1 or ID->HALT occurs; wraps modulo 2^COUNT_WIDTH.
REQ-016 mem_ready SHALL be ignored outside IF and MEM; memory strobes SHALL stay asserted unchanged during a stall.

Reset
REQ-017 On a rising edge with reset_n=0: state<=IF, instret<=0, regardless of current state (including MEM stall, HALT).
REQ-018 After reset the first cycle SHALL show IF outputs (mem_read=1, i_or_d=0); an in-flight store is abandoned, no pc_write issued.

Verification
REQ-019 R-type add, mem_ready=1 always: states IF,ID,EX,WB,IF; reg_write=1 only in WB; instret 0->1 after 4 cycles.
REQ-020 LOAD with mem_ready=0 for 3 cycles in MEM: MEM held 4 cycles with mem_read=1, i_or_d=1; then WB with wb_sel=01; 5+3=8 cycles total.
REQ-021 BRANCH alu_bcond=1 -> EX pc_source=01; alu_bcond=0 -> pc_source=10; both 3 cycles, instret +1.
REQ-022 ECALL ecall_halt=1 -> HALT after ID, halted=1 held 10 cycles, instret +1; ecall_halt=0 -> IF, pc_source=10.
REQ-023 STORE, reset_n=0 during MEM stall -> next state IF, instret=0, mem_write=0, no pc_write.
REQ-024 Unknown opcode 7'b1111111 -> ID issues pc_write=1, pc_source=10, returns to IF in 2 cycles.
